// File: rtl/shift_pkg.sv
// shift_pkg: op codes and helpers shared by the shift pipeline.
package shift_pkg;
  typedef enum logic [2:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_e;
  function automatic logic is_pass(input logic [2:0] op);
    return op > SHIFT_ROR;
  endfunction
endpackage

// File: rtl/shift_pipe_if.sv
// shift_pipe_if: valid/ready op and result channels of the shift pipeline.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  modport master (
    output flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_stage.sv
// shift_stage: one conditional shift/rotate by AMOUNT followed by its pipeline register.
module shift_stage
  import shift_pkg::*;
#(
  parameter int AMOUNT  = 1,
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic               src_valid,
  input  logic [WIDTH-1:0]   src_data,
  input  logic [SHAMT_W-1:0] src_shamt,
  input  logic [2:0]         src_op,
  input  logic [TAG_W-1:0]   src_tag,
  input  logic               src_sign,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] shamt,
  output logic [2:0]         op,
  output logic [TAG_W-1:0]   tag,
  output logic               sign
);
  localparam int K = $clog2(AMOUNT);
  logic [WIDTH-1:0] res;
  assign res = !src_shamt[K] || is_pass(src_op) ? src_data :
               src_op == SHIFT_SLL ? src_data << AMOUNT :
               src_op == SHIFT_SRL ? src_data >> AMOUNT :
               src_op == SHIFT_SRA ? {{AMOUNT{src_sign}}, src_data[WIDTH-1:AMOUNT]} :
               src_op == SHIFT_ROL ? {src_data[WIDTH-AMOUNT-1:0], src_data[WIDTH-1:WIDTH-AMOUNT]} :
                                     {src_data[AMOUNT-1:0], src_data[WIDTH-1:AMOUNT]};
  // flush only clears valid; payload registers keep their contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      op    <= '0;
      tag   <= '0;
      sign  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= src_valid;
      data  <= res;
      shamt <= src_shamt;
      op    <= src_op;
      tag   <= src_tag;
      sign  <= src_sign;
    end
  end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter, one shamt bit per stage, valid/ready with tag sideband.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  shift_pipe_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  logic               adv;
  logic               v  [SHAMT_W+1];
  logic [WIDTH-1:0]   d  [SHAMT_W+1];
  logic [SHAMT_W-1:0] sh [SHAMT_W+1];
  logic [2:0]         op [SHAMT_W+1];
  logic [TAG_W-1:0]   tg [SHAMT_W+1];
  logic               sg [SHAMT_W+1];
  logic               unused_tail;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign v[0]  = bus.in_valid;
  assign d[0]  = bus.in_data;
  assign sh[0] = bus.in_shamt;
  assign op[0] = bus.in_op;
  assign tg[0] = bus.in_tag;
  assign sg[0] = bus.in_data[WIDTH-1];
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .AMOUNT (1 << k),
      .WIDTH  (WIDTH),
      .TAG_W  (TAG_W),
      .SHAMT_W(SHAMT_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (adv),
      .flush    (bus.flush),
      .src_valid(v[k]),
      .src_data (d[k]),
      .src_shamt(sh[k]),
      .src_op   (op[k]),
      .src_tag  (tg[k]),
      .src_sign (sg[k]),
      .valid    (v[k+1]),
      .data     (d[k+1]),
      .shamt    (sh[k+1]),
      .op       (op[k+1]),
      .tag      (tg[k+1]),
      .sign     (sg[k+1])
    );
  end
  assign bus.out_valid = v[SHAMT_W];
  assign bus.out_data  = d[SHAMT_W];
  assign bus.out_tag   = tg[SHAMT_W];
  assign unused_tail   = ^{sh[SHAMT_W], op[SHAMT_W], sg[SHAMT_W]};
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe at WIDTH=16 (latency 4).
module tb_shift_pipe;
  localparam int W = 16;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int rcv = 0;
  logic [W+T-1:0] q[$];
  shift_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();
  shift_pipe #(.WIDTH(W), .TAG_W(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge rst_n) q.delete();
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got data=%h tag=%h, required no output", bus.out_data, bus.out_tag);
      end else begin
        logic [W+T-1:0] e;
        e = q.pop_front();
        if ({bus.out_data, bus.out_tag} !== e) begin
          n_fail++;
          $display("FAIL result: got data=%h tag=%h, required data=%h tag=%h",
                   bus.out_data, bus.out_tag, e[W+T-1:T], e[T-1:0]);
        end
        rcv++;
      end
    end
  end
  function automatic logic [W-1:0] model(input logic [W-1:0] dd, input int s, input int o);
    case (o)
      0:       return dd << s;
      1:       return dd >> s;
      2:       return W'($signed(dd) >>> s);
      3:       return (dd << s) | (dd >> (W - s));
      4:       return (dd >> s) | (dd << (W - s));
      default: return dd;
    endcase
  endfunction
  task automatic issue(input logic [W-1:0] dd, input logic [3:0] s, input logic [2:0] o,
                       input logic [T-1:0] tag, input logic [W-1:0] exp);
    bit r = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = dd;
    bus.in_shamt = s;
    bus.in_op    = o;
    bus.in_tag   = tag;
    for (int i = 0; i < 100 && !r; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (r) q.push_back({exp, tag});
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0 for 100 cycles, required 1");
    end
  endtask
  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2;
    n_checks += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0000", bus.out_data); end
    if (bus.out_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h, required 0", bus.out_tag); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.in_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_sll_sweep;
    bit ok;
    for (int j = 0; j < 16; j++) begin
      issue(16'h000F, 4'(j), 3'd0, 4'(j), model(16'h000F, j, 0));
      n_checks++;
      if (bus.out_valid !== (j >= 3)) begin
        n_fail++;
        $display("FAIL sll_latency[%0d]: got out_valid=%b, required %b", j, bus.out_valid, j >= 3);
      end
    end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sll_drain: got %0d pending, required 0", q.size()); end
  endtask
  task automatic test_modes;
    bit ok;
    int r0 = rcv;
    issue(16'h8000, 4'd15, 3'd2, 4'h1, 16'hFFFF);
    issue(16'h8000, 4'd15, 3'd1, 4'h2, 16'h0001);
    issue(16'h7FF0, 4'd4,  3'd2, 4'h3, 16'h07FF);
    issue(16'h8001, 4'd1,  3'd3, 4'h4, 16'h0003);
    issue(16'h0001, 4'd4,  3'd4, 4'h5, 16'h1000);
    issue(16'hBEEF, 4'd9,  3'd7, 4'h6, 16'hBEEF);
    issue(16'h1234, 4'd0,  3'd3, 4'h7, 16'h1234);
    issue(16'hC3A5, 4'd0,  3'd2, 4'h8, 16'hC3A5);
    drain(ok);
    n_checks++;
    if (!ok || rcv - r0 !== 8) begin n_fail++; $display("FAIL modes_count: got %0d results, required 8", rcv - r0); end
  endtask
  task automatic test_stall;
    bit ok;
    int r0 = rcv;
    fork
      for (int i = 0; i < 10; i++) begin
        logic [W-1:0] dd;
        int s, o;
        dd = 16'($urandom);
        s  = $urandom_range(15, 0);
        o  = $urandom_range(7, 0);
        issue(dd, 4'(s), 3'(o), 4'(i), model(dd, s, o));
      end
      begin
        logic [W-1:0] hd;
        logic [T-1:0] ht;
        repeat (7) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 0) begin
            hd = bus.out_data;
            ht = bus.out_tag;
          end
          n_checks += 2;
          if (bus.in_ready !== !bus.out_valid) begin
            n_fail++;
            $display("FAIL stall_ready[%0d]: got %b, required %b", i, bus.in_ready, !bus.out_valid);
          end
          if ({bus.out_valid, bus.out_data, bus.out_tag} !== {1'b1, hd, ht}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b d=%h t=%h, required v=1 d=%h t=%h",
                     i, bus.out_valid, bus.out_data, bus.out_tag, hd, ht);
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain(ok);
    n_checks++;
    if (!ok || rcv - r0 !== 10) begin n_fail++; $display("FAIL stall_count: got %0d results, required 10", rcv - r0); end
  endtask
  task automatic test_flush;
    bit ok;
    int r0 = rcv;
    issue(16'h0101, 4'd1, 3'd0, 4'hA, model(16'h0101, 1, 0));
    issue(16'h0202, 4'd2, 3'd1, 4'hB, model(16'h0202, 2, 1));
    issue(16'h0303, 4'd3, 3'd3, 4'hC, model(16'h0303, 3, 3));
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0404;
    bus.in_tag   = 4'hD;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill[%0d]: got out_valid=%b, required 0", i, bus.out_valid); end
    end
    @(posedge clk);
    #1;
    issue(16'h00F0, 4'd4, 3'd4, 4'hE, model(16'h00F0, 4, 4));
    drain(ok);
    n_checks++;
    if (!ok || rcv - r0 !== 1) begin n_fail++; $display("FAIL flush_after: got %0d results, required 1", rcv - r0); end
  endtask
  task automatic test_reset_mid;
    bit ok;
    int r0;
    for (int i = 0; i < 5; i++) issue(16'h1111 * 16'(i + 1), 4'(i + 1), 3'd0, 4'(i), model(16'h1111 * 16'(i + 1), i + 1, 0));
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b, required 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b, required 0", bus.out_valid); end
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL mid_reset_data: got %h, required 0000", bus.out_data); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b, required 1", bus.in_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    r0 = rcv;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_stale[%0d]: got out_valid=%b, required 0", i, bus.out_valid); end
    end
    @(posedge clk);
    #1;
    issue(16'hA5A5, 4'd8, 3'd3, 4'h9, model(16'hA5A5, 8, 3));
    drain(ok);
    n_checks++;
    if (!ok || rcv - r0 !== 1) begin n_fail++; $display("FAIL post_reset_count: got %0d results, required 1", rcv - r0); end
  endtask
  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_sll_sweep();
    test_modes();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter with valid/ready handshake, used as the shift execution unit of the RV datapath; the sequential, binary-shamt, multi-mode successor of the 16-bit one-hot combinational shifter. Applies one shamt bit per registered stage, so throughput is one operation per cycle at any WIDTH, with backpressure from the consumer and a per-op tag carried alongside.

## Interface
- WIDTH, 32: data width; power of two, 8..64.
- TAG_W, 4: width of sideband tag carried with each op (≥1).
- SHAMT_W (localparam), $clog2(WIDTH): shift-amount width, also the stage count LAT.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; kills every in-flight op.
- in_valid  in  1  op offered.
- in_ready  out  1  op accepted when in_valid & in_ready.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  binary shift amount.
- in_op  in  3  operation code (see Operation).
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Op codes: 0 SLL, 1 SRL (zero fill), 2 SRA (fill with operand MSB), 3 ROL, 4 ROR; 5..7 pass-through (out_data = in_data; shamt ignored).
- Stage k (k = 0..LAT-1) shifts/rotates by 2^k when shamt bit k is 1, else passes data. Each stage register holds valid, data, remaining shamt bits, op, tag, and the sign bit for SRA.
- Result = exact single-step shift by in_shamt; shamt 0 returns in_data for all ops.
- Pipeline advance: adv = !out_valid | out_ready. All stages load together when adv = 1 and hold otherwise; in_ready = adv (combinational).
- Bubbles are not squeezed out; a stalled pipe keeps its bubble pattern.
- Ops leave in issue order; none dropped or duplicated.
- flush = 1: all stage valids cleared at the next edge (flush wins over adv and over a same-cycle input handshake, which is discarded). Data registers keep their values.

## Timing
- Reset (rst_n low, async): all valids 0 → out_valid = 0; out_data = 0, out_tag = 0; in_ready = 1 while in reset (it follows out_valid = 0).
- Latency: op accepted at edge N appears with out_valid = 1 after edge N+LAT-1 when unstalled (LAT registered stages, output driven from the last stage register). WIDTH=16 → 4 cycles, WIDTH=32 → 5.
- Throughput: 1 op/cycle with out_ready held high.
- out_valid/out_data/out_tag stay stable while out_valid & !out_ready.
- Reset asserted mid-stream: everything in flight lost; after release, first out_valid only for ops accepted after release.
- Simultaneous out_ready and in_valid on a full pipe: one retire and one accept on the same edge.

## Structure
- Package shift_pkg: op-code constants/enum (SHIFT_SLL..SHIFT_ROR), helper for pass-through test.
- Sub-module shift_stage (parameter AMOUNT = 2^k, WIDTH, TAG_W): one combinational shift step plus its pipeline register and enable; shift_pipe instantiates SHAMT_W of them via generate and owns adv/in_ready/flush.

## Test plan
- WIDTH=16: SLL, in_data 0x000F, shamt 0..15 back-to-back, out_ready=1 → outputs 0x000F<<j in order, first at 4 cycles, one per cycle, tags 0..15 matching.
- SRA 0x8000 shamt 15 → 0xFFFF; SRL 0x8000 shamt 15 → 0x0001; SRA 0x7FF0 shamt 4 → 0x07FF.
- ROL 0x8001 shamt 1 → 0x0003; ROR 0x0001 shamt 4 → 0x1000; op 7 with 0xBEEF shamt 9 → 0xBEEF.
- Stream 10 ops, drop out_ready for 6 cycles mid-stream → in_ready low while out_valid & !out_ready, output held stable, all 10 results received exactly once in order.
- Pulse flush with 3 ops in flight and in_valid=1 same cycle → none of the 4 ever appears; next op accepted emerges normally.
- Assert rst_n low for 1 cycle mid-stream → out_valid drops immediately, out_data=0, no stale result after release.
